// File: rtl/spike_shift_pipe_if.sv
// rtl/spike_shift_pipe_if.sv - handshake/data bundle for spike_shift_pipe
//
// Groups the upstream (in_*) and downstream (out_*) valid/ready channels.
//   slave  : the shifter side (drives in_ready, out_valid, out_spikes, out_drop)
//   master : the environment side (drives in_valid, in_spikes, in_shift, in_wrap, out_ready)
// Channel c of in_spikes/out_spikes occupies [c*LEN +: LEN], bit 0 = t=0.
// in_shift holds one signed SHW-bit shift per channel at [c*SHW +: SHW].
interface spike_shift_pipe_if #(
    parameter int LEN           = 8,
    parameter int NUM_CH        = 4,
    parameter int MAX_SHIFT_MAG = 2
);
    localparam int SHW = $clog2(MAX_SHIFT_MAG + 1) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*LEN-1:0]   in_spikes;
    logic [NUM_CH*SHW-1:0]   in_shift;
    logic                    in_wrap;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*LEN-1:0]   out_spikes;
    logic [NUM_CH-1:0]       out_drop;

    modport slave (
        input  in_valid, in_spikes, in_shift, in_wrap, out_ready,
        output in_ready, out_valid, out_spikes, out_drop
    );

    modport master (
        output in_valid, in_spikes, in_shift, in_wrap, out_ready,
        input  in_ready, out_valid, out_spikes, out_drop
    );
endinterface

// File: rtl/spike_shift_pipe.sv
// rtl/spike_shift_pipe.sv - two-stage multi-channel signed spike-vector time shifter
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          spike_shift_pipe_if.slave: in_valid/in_ready/in_spikes/in_shift/in_wrap,
//                out_valid/out_ready/out_spikes/out_drop
//   drop_sticky  per-channel OR of out_drop since the last drop_clr
//   drop_clr     synchronous clear of drop_sticky and drop_cnt (a same-cycle drop wins)
//   drop_cnt     saturating count of dropped spikes; tied to 0 unless DROP_CNT_EN is defined
//
// Shift rule per channel: out[j] = in[j+k]; positive k moves spikes toward t=0.
// Shift magnitude is clamped to MAX_SHIFT_MAG when captured in S1.
module spike_shift_pipe #(
    parameter int LEN           = 8,
    parameter int NUM_CH        = 4,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spike_shift_pipe_if.slave      bus,
    output logic [NUM_CH-1:0]      drop_sticky,
    input  logic                   drop_clr,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int SHW = $clog2(MAX_SHIFT_MAG + 1) + 1;
    localparam logic signed [SHW-1:0] K_MAX = SHW'(MAX_SHIFT_MAG);
    localparam logic signed [SHW-1:0] K_MIN = -K_MAX;

    function automatic logic signed [SHW-1:0] clamp_k(input logic signed [SHW-1:0] k);
        if (k > K_MAX)      return K_MAX;
        else if (k < K_MIN) return K_MIN;
        else                return k;
    endfunction

    // Returns {lost_bits, shifted}. lost_bits marks input spikes pushed out of the
    // window; with wrap they re-enter from the other end, so nothing is lost.
    function automatic logic [2*LEN-1:0] shift_ch(input logic [LEN-1:0]        ip,
                                                   input logic signed [SHW-1:0] k,
                                                   input logic                  wrap);
        logic [SHW-1:0] m;
        logic [LEN-1:0] ones;
        logic [LEN-1:0] op;
        logic [LEN-1:0] lost;
        ones = '1;
        m    = k[SHW-1] ? -k : k;
        if (!k[SHW-1]) begin
            op   = ip >> m;
            lost = ip & ~(ones << m);
            if (wrap) op = op | (ip << (LEN - m));
        end else begin
            op   = ip << m;
            lost = ip & ~(ones >> m);
            if (wrap) op = op | (ip >> (LEN - m));
        end
        if (wrap) lost = '0;
        return {lost, op};
    endfunction

    // Stage state
    logic                  s1_valid;
    logic [NUM_CH*LEN-1:0] s1_spikes;
    logic [NUM_CH*SHW-1:0] s1_shift;
    logic                  s1_wrap;
    logic                  s2_valid;
    logic [NUM_CH*LEN-1:0] s2_spikes;
    logic [NUM_CH-1:0]     s2_drop;

    logic                  s1_adv;
    logic                  s2_adv;
    logic                  s2_load;
    logic [NUM_CH*SHW-1:0] clamped;
    logic [NUM_CH*LEN-1:0] nxt_spikes;
    logic [NUM_CH-1:0]     nxt_drop;
`ifdef DROP_CNT_EN
    localparam int POP_W = $clog2(NUM_CH*LEN + 1);
    logic [NUM_CH*LEN-1:0] nxt_lost;
    logic [POP_W-1:0]      nxt_pop;
`endif

    // A stage may take new data when it is empty or its content leaves this cycle.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign s2_load      = s2_adv && s1_valid;
    assign bus.in_ready = s1_adv;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [2*LEN-1:0] res;
        assign clamped[c*SHW +: SHW]    = clamp_k(bus.in_shift[c*SHW +: SHW]);
        assign res                      = shift_ch(s1_spikes[c*LEN +: LEN],
                                                   s1_shift[c*SHW +: SHW], s1_wrap);
        assign nxt_spikes[c*LEN +: LEN] = res[LEN-1:0];
        assign nxt_drop[c]              = |res[2*LEN-1:LEN];
`ifdef DROP_CNT_EN
        assign nxt_lost[c*LEN +: LEN]   = res[2*LEN-1:LEN];
`endif
    end

`ifdef DROP_CNT_EN
    assign nxt_pop = POP_W'($countones(nxt_lost));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_spikes <= '0;
            s1_shift  <= '0;
            s1_wrap   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_spikes <= bus.in_spikes;
                s1_shift  <= clamped;
                s1_wrap   <= bus.in_wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_spikes <= '0;
            s2_drop   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_spikes <= nxt_spikes;
                s2_drop   <= nxt_drop;
            end
        end
    end

    // Clear first, then OR in the new load so a coincident drop survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_sticky <= '0;
        else        drop_sticky <= (drop_clr ? '0 : drop_sticky) | (s2_load ? nxt_drop : '0);
    end

`ifdef DROP_CNT_EN
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   cnt_sum;
    assign cnt_inc = s2_load ? CNT_W'(nxt_pop) : '0;
    assign cnt_sum = {1'b0, drop_cnt} + {1'b0, cnt_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          drop_cnt <= '0;
        else if (drop_clr)   drop_cnt <= cnt_inc;
        else if (cnt_sum[CNT_W]) drop_cnt <= '1;
        else                 drop_cnt <= cnt_sum[CNT_W-1:0];
    end
`else
    assign drop_cnt = '0;
`endif

    assign bus.out_valid  = s2_valid;
    assign bus.out_spikes = s2_spikes;
    assign bus.out_drop   = s2_drop;
endmodule

// File: tb/tb_spike_shift_pipe.sv
// tb/tb_spike_shift_pipe.sv - directed self-checking bench for spike_shift_pipe
module tb_spike_shift_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        drop_clr;
    logic [1:0]  drop_sticky;
    logic [15:0] drop_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    spike_shift_pipe_if #(.LEN(8), .NUM_CH(2), .MAX_SHIFT_MAG(2)) bus ();

    spike_shift_pipe #(.LEN(8), .NUM_CH(2), .MAX_SHIFT_MAG(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .drop_sticky (drop_sticky),
        .drop_clr    (drop_clr),
        .drop_cnt    (drop_cnt)
    );

    function automatic logic [15:0] ec(input int v);
`ifdef DROP_CNT_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] sp, input logic [5:0] sh, input logic wr);
        bus.in_valid  = 1'b1;
        bus.in_spikes = sp;
        bus.in_shift  = sh;
        bus.in_wrap   = wr;
    endtask

    // One transaction through an idle pipeline with out_ready=1.
    task automatic run_one(input string tag, input logic [15:0] sp, input logic [5:0] sh,
                           input logic wr, input logic [15:0] exp_sp, input logic [1:0] exp_dr);
        drive(sp, sh, wr);
        #1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
        step();
        chk({tag, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_spikes"}, 64'(bus.out_spikes), 64'(exp_sp));
        chk({tag, "_drop"}, 64'(bus.out_drop), 64'(exp_dr));
    endtask

    logic [15:0] vec [4];
    int          in_idx;
    int          out_idx;
    logic        acc;

    initial begin
        vec[0] = 16'h0011; vec[1] = 16'h0022; vec[2] = 16'h0033; vec[3] = 16'h0044;
        rst_n = 1'b0; drop_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_spikes = '0; bus.in_shift = '0; bus.in_wrap = 1'b0;
        bus.out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_spikes", 64'(bus.out_spikes), 64'd0);
        chk("rst_out_drop", 64'(bus.out_drop), 64'd0);
        chk("rst_sticky", 64'(drop_sticky), 64'd0);
        chk("rst_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // ch0 bit1, k=+1 -> bit0
        run_one("t1", {8'h00, 8'h02}, {3'b000, 3'b001}, 1'b0, {8'h00, 8'h01}, 2'b00);
        chk("t1_sticky", 64'(drop_sticky), 64'd0);
        step();
        // ch0 bits1,7, k=+2 -> bit5, bit1 lost
        run_one("t2", {8'h00, 8'h82}, {3'b000, 3'b010}, 1'b0, {8'h00, 8'h20}, 2'b01);
        chk("t2_sticky", 64'(drop_sticky), 64'd1);
        chk("t2_cnt", 64'(drop_cnt), 64'(ec(1)));
        step();
        // same with wrap: bit1 -> bit7
        run_one("t3", {8'h00, 8'h82}, {3'b000, 3'b010}, 1'b1, {8'h00, 8'hA0}, 2'b00);
        chk("t3_cnt", 64'(drop_cnt), 64'(ec(1)));
        step();
        // ch1 bits0,6, k=-2 -> bit2, bit6 lost
        run_one("t4", {8'h41, 8'h00}, {3'b110, 3'b000}, 1'b0, {8'h04, 8'h00}, 2'b10);
        chk("t4_sticky", 64'(drop_sticky), 64'd3);
        chk("t4_cnt", 64'(drop_cnt), 64'(ec(2)));
        step();
        // k=-3 clamps to -2
        run_one("t5", {8'h41, 8'h00}, {3'b101, 3'b000}, 1'b0, {8'h04, 8'h00}, 2'b10);
        chk("t5_cnt", 64'(drop_cnt), 64'(ec(3)));
        step();
        // k=+3 clamps to +2
        run_one("t6", {8'h00, 8'h82}, {3'b000, 3'b011}, 1'b0, {8'h00, 8'h20}, 2'b01);
        chk("t6_cnt", 64'(drop_cnt), 64'(ec(4)));
        step();

        // plain clear
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("clr_sticky", 64'(drop_sticky), 64'd0);
        chk("clr_cnt", 64'(drop_cnt), 64'd0);

        // clear coincident with a dropping S2 load
        drive({8'h00, 8'h82}, {3'b000, 3'b010}, 1'b0);
        #1;
        step();
        bus.in_valid = 1'b0;
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("clrset_valid", 64'(bus.out_valid), 64'd1);
        chk("clrset_sticky", 64'(drop_sticky), 64'd1);
        chk("clrset_cnt", 64'(drop_cnt), 64'(ec(1)));
        step();

        // backpressure: A,B fill the pipe, C and D wait
        bus.out_ready = 1'b0;
        drive(vec[0], 6'd0, 1'b0);
        #1;
        chk("stall_rdy_a", 64'(bus.in_ready), 64'd1);
        step();
        drive(vec[1], 6'd0, 1'b0);
        #1;
        chk("stall_rdy_b", 64'(bus.in_ready), 64'd1);
        step();
        drive(vec[2], 6'd0, 1'b0);
        #1;
        chk("stall_rdy_c", 64'(bus.in_ready), 64'd0);
        chk("stall_hold0", 64'(bus.out_spikes), 64'(vec[0]));
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_rdy_hold", 64'(bus.in_ready), 64'd0);
            chk("stall_valid_hold", 64'(bus.out_valid), 64'd1);
            chk("stall_hold", 64'(bus.out_spikes), 64'(vec[0]));
        end
        bus.out_ready = 1'b1;
        #1;
        in_idx = 2;
        out_idx = 0;
        for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                chk("stall_order", 64'(bus.out_spikes), 64'(vec[out_idx]));
                out_idx++;
            end
            step();
            if (acc) begin
                in_idx++;
                if (in_idx < 4) drive(vec[in_idx], 6'd0, 1'b0);
                else            bus.in_valid = 1'b0;
            end
            #1;
        end
        chk("stall_count", 64'(out_idx), 64'd4);
        bus.in_valid = 1'b0;
        step();

        // async reset with both stages full
        bus.out_ready = 1'b0;
        drive({8'h00, 8'h55}, 6'd0, 1'b0);
        step();
        drive({8'h00, 8'h66}, 6'd0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("prerst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_spikes", 64'(bus.out_spikes), 64'd0);
        chk("arst_sticky", 64'(drop_sticky), 64'd0);
        chk("arst_cnt", 64'(drop_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
        run_one("post_rst", {8'h00, 8'h02}, {3'b000, 3'b001}, 1'b0, {8'h00, 8'h01}, 2'b00);
        step();
        chk("post_rst_drain", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_shift_pipe.md
Name: spike_shift_pipe

Overview:
- Multi-channel, pipelined, bi-directional time shifter for thermometer/spike-encoded volleys in the temporal datapath.
- Each channel's LEN-bit spike vector is shifted by its own signed binary shift amount.
- Wrap-around is selectable per transaction rather than fixed at elaboration.
- Valid/ready handshake at both ends, with per-channel reporting of spikes lost off the window edge.

Parameters:
- LEN, 8, bits per channel spike vector; index 0 = t=0.
- NUM_CH, 4, number of independent channels.
- MAX_SHIFT_MAG, 2, largest legal shift magnitude.
- SHW, $clog2(MAX_SHIFT_MAG+1)+1, width of the signed shift field (derived; do not override).
- CNT_W, 16, width of the dropped-spike counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  block can accept this cycle.
- in_spikes  in  NUM_CH*LEN  channel c occupies bits [c*LEN +: LEN]; bit c*LEN+0 is t=0.
- in_shift  in  NUM_CH*SHW  signed two's-complement shift per channel.
- in_wrap  in  1  1 = wrap-around, 0 = discard out-of-window spikes.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_spikes  out  NUM_CH*LEN  shifted vectors, same packing as in_spikes.
- out_drop  out  NUM_CH  per-channel: this result lost ≥1 spike.
- drop_sticky  out  NUM_CH  per-channel OR of out_drop since last clear.
- drop_clr  in  1  synchronous clear of drop_sticky and drop_cnt.
- drop_cnt  out  CNT_W  total dropped spikes (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): all outputs and internal state go to 0 (out_valid=0, out_spikes=0, out_drop=0, drop_sticky=0, drop_cnt=0); in_ready=1 once rst_n is high. Reset mid-transaction discards all in-flight data.
- Shift rule for channel shift k: Op[j] = Ip[j+k]. k>0 moves spikes earlier (toward index 0); k<0 moves them later.
- Clamp: k>+MAX_SHIFT_MAG is treated as +MAX_SHIFT_MAG; k<−MAX_SHIFT_MAG is treated as −MAX_SHIFT_MAG. Clamping is applied at S1 capture.
- No-wrap (in_wrap=0): out-of-range source index (j+k<0 or ≥LEN) yields 0. An input spike at p is dropped if p−k lies outside [0,LEN−1].
- Wrap (in_wrap=1): source index is taken modulo LEN; spikes are never dropped.
- Union vectors (multiple spikes per channel) are shifted bit-parallel.
- Pipeline:
  - S1 registers spikes, clamped shifts and wrap.
  - S2 registers the shifted result, out_drop and drop popcount.
  - Latency is 2 cycles from accept to out_valid when unstalled; throughput is 1 transaction/cycle.
- Handshake:
  - Transfer occurs when valid && ready at each end.
  - S2 advances if it is empty or out_ready=1. S1 advances if it is empty or S2 advances.
  - in_ready = S1 empty or S1 advancing; this is combinational from out_ready.
  - While out_valid=1 and out_ready=0, out_spikes and out_drop hold stable.
  - Two transactions buffer before in_ready falls.
  - in_* signals are don't-care when in_valid=0.
- drop_sticky[c] sets when S2 loads with out_drop[c]=1. If drop_clr and a new drop occur in the same cycle, the set wins.
- No FSM beyond the two per-stage valid bits; stalls never duplicate or lose transactions.

Optional Feature:
- Macro DROP_CNT_EN.
- Defined:
  - drop_cnt adds the popcount of dropped spikes across all channels each time S2 loads.
  - The counter saturates at 2^CNT_W−1.
  - drop_clr loads the cycle's increment (0 if none).
- Undefined: the drop_cnt port remains and is tied to 0; no counter logic is generated.

Test Plan:
- LEN=8, NUM_CH=2, MAX=2, ch0 Ip[0:7]=0100_0000, k=+1, wrap=0 -> ch0 Op=1000_0000, out_drop[0]=0, out_valid exactly 2 cycles after accept.
- ch0 Ip=0100_0001, k=+2, wrap=0 -> Op=0000_0100, out_drop[0]=1, drop_sticky[0]=1, drop_cnt=1 (DROP_CNT_EN). Same input with wrap=1 -> Op=0000_0101, out_drop[0]=0.
- ch1 Ip=1000_0010, k=−2, wrap=0 -> Op=0010_0000, out_drop[1]=1. Then k=−3 with the same Ip -> identical result (clamped).
- out_ready=0, in_valid=1 for 4 cycles with distinct vectors A,B,C,D -> A and B accepted, in_ready=0 from the third cycle, out_spikes=A held stable. Raise out_ready -> A,B,C,D emerge in order with no loss.
- drop_clr asserted in the same cycle as a drop-producing S2 load -> drop_sticky stays 1, drop_cnt equals that load's popcount.
- Assert rst_n=0 with both stages full -> outputs 0 immediately (asynchronously). After release, first new transaction appears after 2 cycles.
